ram_fifo_param: RTL and testbench



---
 rtl/ram_fifo_pkg.sv | 35 +++
 rtl/ram_sdp.sv | 37 +++
 rtl/ram_fifo_param.sv | 139 +++++++++++++
 tb/tb_ram_fifo_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the parametrised RAM FIFO: read-mode constants,
// a constant-time log2 helper and the occupancy-to-flag compare helpers.
package ram_fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    for (int i = 0; i < 32; i++) begin
      if ((x >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic cnt_ge(input int unsigned cnt, input int unsigned lvl);
    return cnt >= lvl;
  endfunction

  function automatic logic cnt_le(input int unsigned cnt, input int unsigned lvl);
    return cnt <= lvl;
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// A read and write to the same address in one cycle returns the old word.
module ram_sdp #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is cleared; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_fifo_param.sv
// Single-clock FIFO over ram_sdp with full power-of-two depth, occupancy count,
// programmable almost flags, sticky error flags, flush and optional FWFT read.
module ram_fifo_param
  import ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AFULL_LVL  = 2 ** ADDR_WIDTH - 4,
  parameter int unsigned AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  flush,
  input  logic                  shift_in,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  shift_out,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW  = clog2(Depth) + 1;
  localparam logic [PtrW-1:0] DepthCnt = PtrW'(Depth);

  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [PtrW-1:0] fetch_q, fetch_d;
  logic [PtrW-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            push_ok, pop_ok, fetch;
  logic [PtrW-1:0] unfetched;
  logic            ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  fifo_flags_t     flags;

  always_comb begin
    flags.full         = (count_q == DepthCnt);
    // In FWFT mode readability is the output register, not the count.
    flags.empty        = (FWFT == FIFO_FWFT) ? !out_valid_q : (count_q == '0);
    flags.almost_full  = cnt_ge(32'(count_q), AFULL_LVL);
    flags.almost_empty = cnt_le(32'(count_q), AEMPTY_LVL);
  end

  assign pop_ok  = shift_out & ~flags.empty;
  assign push_ok = shift_in & (~flags.full | pop_ok);

  // Prefetch whenever RAM holds unread words and the output slot is free or draining.
  assign unfetched = wr_q - fetch_q;
  assign fetch     = (unfetched != '0) & (~out_valid_q | pop_ok);

  always_comb begin
    wr_d        = wr_q;
    rd_d        = rd_q;
    fetch_d     = fetch_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    if (flush) begin
      wr_d        = '0;
      rd_d        = '0;
      fetch_d     = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      if (fetch) begin
        fetch_d     = fetch_q + 1'b1;
        out_valid_d = 1'b1;
      end else if (pop_ok) begin
        out_valid_d = 1'b0;
      end
      if (shift_in & ~push_ok)     ovf_d = 1'b1;
      if (shift_out & flags.empty) udf_d = 1'b1;
    end
    count_d = wr_d - rd_d;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_q        <= '0;
      rd_q        <= '0;
      fetch_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      fetch_q     <= fetch_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign ram_we    = push_ok & ~flush & ~res;
  assign ram_re    = ((FWFT == FIFO_FWFT) ? fetch : pop_ok) & ~flush;
  assign ram_raddr = (FWFT == FIFO_FWFT) ? fetch_q[ADDR_WIDTH-1:0] : rd_q[ADDR_WIDTH-1:0];

  ram_sdp #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (res),
    .we_i    (ram_we),
    .waddr_i (wr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (rdata)
  );

  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  a_count_bound: assert property (@(posedge clk) disable iff (res) count_q <= DepthCnt);
  a_full_empty:  assert property (@(posedge clk) disable iff (res) !(flags.full && flags.empty));

endmodule

// File: tb/tb_ram_fifo_param.sv
// Scoreboard bench: one standard-mode and one FWFT instance, depth 8. Drivers
// queue expected read data; monitors pop and compare when a word is presented.
module tb_ram_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       res0 = 1'b1, flush0 = 1'b0, shift_in0 = 1'b0, shift_out0 = 1'b0;
  logic [7:0] wdata0 = '0, rdata0;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0] count0;

  // FWFT instance
  logic       res1 = 1'b1, flush1 = 1'b0, shift_in1 = 1'b0, shift_out1 = 1'b0;
  logic [7:0] wdata1 = '0, rdata1;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] count1;

  ram_fifo_param #(.WIDTH(8), .ADDR_WIDTH(3), .FWFT(0)) u_std (
    .clk(clk), .res(res0), .flush(flush0), .shift_in(shift_in0), .wdata(wdata0),
    .shift_out(shift_out0), .rdata(rdata0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0),
    .underflow(udf0)
  );

  ram_fifo_param #(.WIDTH(8), .ADDR_WIDTH(3), .FWFT(1)) u_fwft (
    .clk(clk), .res(res1), .flush(flush1), .shift_in(shift_in1), .wdata(wdata1),
    .shift_out(shift_out1), .rdata(rdata1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1),
    .underflow(udf1)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       pop_exp0 = 1'b0;
  logic       pend0    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Standard mode: a word is presented the cycle after an accepted pop.
  always @(posedge clk) pend0 <= pop_exp0;

  always @(negedge clk) begin
    if (pend0) begin
      if (q0.size() == 0) check("std_sb_underrun", 32'(rdata0), 32'hFFFF_FFFF);
      else check("std_rdata", 32'(rdata0), 32'(q0.pop_front()));
    end
  end

  // FWFT mode: the presented word is consumed at the next edge when popping.
  always @(negedge clk) begin
    if (shift_out1 && !empty1 && !res1) begin
      if (q1.size() == 0) check("fwft_sb_underrun", 32'(rdata1), 32'hFFFF_FFFF);
      else check("fwft_rdata", 32'(rdata1), 32'(q1.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] last0;
    last0 = '0;

    // Reset both instances
    tick();
    tick();
    res0 = 1'b0;
    res1 = 1'b0;
    check("rst_count", 32'(count0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_aempty", 32'(ae0), 32'd1);
    check("rst_afull", 32'(af0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_udf", 32'(udf0), 32'd0);
    check("rst_rdata", 32'(rdata0), 32'd0);

    // Fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      shift_in0 = 1'b1;
      wdata0    = 8'(i);
      tick();
      check("fill_count", 32'(count0), 32'(i));
      check("fill_afull", 32'(af0), 32'(i >= 4));
      check("fill_aempty", 32'(ae0), 32'(i <= 4));
    end
    check("fill_full", 32'(full0), 32'd1);
    wdata0 = 8'h09;
    tick();
    shift_in0 = 1'b0;
    check("ovf_set", 32'(ovf0), 32'd1);
    check("ovf_count", 32'(count0), 32'd8);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      shift_out0 = 1'b1;
      pop_exp0   = 1'b1;
      q0.push_back(8'(i));
      tick();
    end
    shift_out0 = 1'b0;
    pop_exp0   = 1'b0;
    check("drain_empty", 32'(empty0), 32'd1);
    check("drain_count", 32'(count0), 32'd0);
    tick();
    shift_out0 = 1'b1;
    tick();
    shift_out0 = 1'b0;
    check("udf_set", 32'(udf0), 32'd1);
    check("udf_rdata_hold", 32'(rdata0), 32'h08);

    // Full, then push+pop in the same cycle
    for (int i = 1; i <= 8; i++) begin
      shift_in0 = 1'b1;
      wdata0    = 8'(8'h10 + i);
      tick();
    end
    check("refill_full", 32'(full0), 32'd1);
    wdata0     = 8'hAA;
    shift_out0 = 1'b1;
    pop_exp0   = 1'b1;
    q0.push_back(8'h11);
    tick();
    shift_in0 = 1'b0;
    check("pp_count", 32'(count0), 32'd8);
    check("pp_full", 32'(full0), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      q0.push_back(8'(8'h10 + i));
      tick();
    end
    q0.push_back(8'hAA);
    tick();
    shift_out0 = 1'b0;
    pop_exp0   = 1'b0;
    check("pp_drain_empty", 32'(empty0), 32'd1);

    // Wrap with interleaved push/pop pairs
    for (int i = 0; i < 20; i++) begin
      d         = 8'($urandom_range(255, 0));
      shift_in0 = 1'b1;
      wdata0    = d;
      tick();
      shift_in0 = 1'b0;
      check("wrap_count_1", 32'(count0), 32'd1);
      shift_out0 = 1'b1;
      pop_exp0   = 1'b1;
      q0.push_back(d);
      tick();
      shift_out0 = 1'b0;
      pop_exp0   = 1'b0;
      check("wrap_count_0", 32'(count0), 32'd0);
      last0 = d;
    end
    tick();

    // Flush with 5 stored words and overflow still set
    for (int i = 1; i <= 5; i++) begin
      shift_in0 = 1'b1;
      wdata0    = 8'(8'h20 + i);
      tick();
    end
    check("pre_flush_count", 32'(count0), 32'd5);
    check("pre_flush_ovf", 32'(ovf0), 32'd1);
    flush0 = 1'b1;
    wdata0 = 8'h26;
    tick();
    flush0    = 1'b0;
    shift_in0 = 1'b0;
    check("flush_count", 32'(count0), 32'd0);
    check("flush_empty", 32'(empty0), 32'd1);
    check("flush_ovf", 32'(ovf0), 32'd0);
    check("flush_udf", 32'(udf0), 32'd0);
    check("flush_rdata_hold", 32'(rdata0), 32'(last0));

    // Reset mid-stream
    for (int i = 1; i <= 3; i++) begin
      shift_in0 = 1'b1;
      wdata0    = 8'(8'h30 + i);
      tick();
    end
    shift_in0  = 1'b0;
    shift_out0 = 1'b1;
    pop_exp0   = 1'b1;
    q0.push_back(8'h31);
    tick();
    shift_out0 = 1'b0;
    pop_exp0   = 1'b0;
    shift_in0  = 1'b1;
    wdata0     = 8'h34;
    tick();
    res0 = 1'b1;
    tick();
    res0      = 1'b0;
    shift_in0 = 1'b0;
    check("res_count", 32'(count0), 32'd0);
    check("res_empty", 32'(empty0), 32'd1);
    check("res_rdata", 32'(rdata0), 32'd0);
    check("res_ovf", 32'(ovf0), 32'd0);
    check("res_aempty", 32'(ae0), 32'd1);

    // FWFT: push into empty at edge N, visible after edge N+1
    check("fwft_rst_empty", 32'(empty1), 32'd1);
    shift_in1 = 1'b1;
    wdata1    = 8'h5A;
    q1.push_back(8'h5A);
    tick();
    shift_in1 = 1'b0;
    check("fwft_n_empty", 32'(empty1), 32'd1);
    check("fwft_n_count", 32'(count1), 32'd1);
    tick();
    check("fwft_n1_empty", 32'(empty1), 32'd0);
    check("fwft_n1_rdata", 32'(rdata1), 32'h5A);
    for (int i = 1; i <= 3; i++) begin
      shift_in1 = 1'b1;
      wdata1    = 8'(8'hC0 + i);
      q1.push_back(8'(8'hC0 + i));
      tick();
    end
    shift_in1 = 1'b0;
    check("fwft_count4", 32'(count1), 32'd4);
    shift_out1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fwft_stream_nogap", 32'(empty1), 32'd0);
      tick();
    end
    shift_out1 = 1'b0;
    check("fwft_end_empty", 32'(empty1), 32'd1);
    check("fwft_end_count", 32'(count1), 32'd0);
    check("fwft_udf", 32'(udf1), 32'd0);

    tick();
    tick();
    check("std_sb_drained", 32'(q0.size()), 32'd0);
    check("fwft_sb_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
